// File: rtl/yuv_axis_pkg.sv
// Shared definitions for the camera FIFO to AXI4-Stream video bridge:
// FIFO word layout, skid-buffer entry layout and classifier state encoding.
package yuv_axis_pkg;

    localparam int VSYNC_BIT = 17;
    localparam int HREF_BIT  = 16;
    localparam int PIX_MSB   = 15;
    localparam int WORD_W    = 18;

    // Skid-buffer entry: {tuser, tlast, pixel}
    localparam int BUF_USER_BIT = 17;
    localparam int BUF_LAST_BIT = 16;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry ring buffer driving an AXI4-Stream master; the head entry stays
// put until its handshake, so the output is stable while stalled.
module axis_skid_buffer #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic [1:0]   o_occ,
    output logic         o_tvalid,
    input  logic         i_tready,
    output logic [W-1:0] o_tdata
);

    logic [W-1:0] r_mem [2];
    logic         r_wp;
    logic         r_rp;
    logic [1:0]   r_cnt;
    logic         w_pop;

    assign w_pop    = o_tvalid && i_tready;
    assign o_tvalid = (r_cnt != 2'd0);
    assign o_tdata  = r_mem[r_rp];
    assign o_occ    = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/yuv_fifo_to_axis.sv
// Drains the camera capture FIFO, drops sync markers and frames pixels into
// AXI4-Stream video lines (tlast) and frames (tuser) with credit-based reads.
module yuv_fifo_to_axis
    import yuv_axis_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fifo_empty,
    input  logic [17:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic [15:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tuser,
    output logic        m_axis_video_tlast,
    output logic        line_err,
    output logic        frame_err
);

    localparam int HW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int VW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);

    state_t            r_state, w_state_nxt;
    logic [HW-1:0]     r_h, w_h_nxt;
    logic [VW-1:0]     r_v, w_v_nxt;
    logic              r_sof, w_sof_nxt;
    logic              r_rd_pend;
    logic              r_arm;
    logic              r_line_err, w_line_err_nxt;
    logic              r_frame_err, w_frame_err_nxt;
    logic              w_push;
    logic [WORD_W-1:0] w_push_data;
    logic [WORD_W-1:0] w_buf_data;
    logic [1:0]        w_occ;
    logic              w_pop;
    logic [2:0]        w_used;
    logic [2:0]        w_limit;
    logic              w_is_pix, w_is_frm, w_is_line;

    // A read issued last cycle is the word on fifo_dout now.
    assign w_is_pix  = r_rd_pend &&  fifo_dout[HREF_BIT];
    assign w_is_frm  = r_rd_pend && !fifo_dout[HREF_BIT] &&  fifo_dout[VSYNC_BIT];
    assign w_is_line = r_rd_pend && !fifo_dout[HREF_BIT] && !fifo_dout[VSYNC_BIT];

    // Buffer slots plus the in-flight word must never exceed two entries.
    assign w_pop      = m_axis_video_tvalid && m_axis_video_tready;
    assign w_used     = {1'b0, w_occ} + {2'b00, r_rd_pend};
    assign w_limit    = 3'd2 + {2'b00, w_pop};
    assign fifo_rd_en = r_arm && !fifo_empty && (w_used < w_limit);

    assign w_push_data = {r_sof, (r_h == H_LAST), fifo_dout[PIX_MSB:0]};

    always_comb begin
        w_state_nxt     = r_state;
        w_h_nxt         = r_h;
        w_v_nxt         = r_v;
        w_sof_nxt       = r_sof;
        w_push          = 1'b0;
        w_line_err_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        unique case (r_state)
            ST_SYNC, ST_DONE: begin
                if (w_is_frm) begin
                    w_state_nxt = ST_ACTIVE;
                    w_sof_nxt   = 1'b1;
                    w_h_nxt     = '0;
                    w_v_nxt     = '0;
                end
            end
            ST_ACTIVE: begin
                if (w_is_pix) begin
                    w_push    = 1'b1;
                    w_sof_nxt = 1'b0;
                    if (r_h == H_LAST) begin
                        w_h_nxt = '0;
                        if (r_v == V_LAST) begin
                            w_v_nxt     = '0;
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_v_nxt = r_v + VW'(1);
                        end
                    end else begin
                        w_h_nxt = r_h + HW'(1);
                    end
                end else if (w_is_line) begin
                    if (r_h != '0) begin
                        w_line_err_nxt = 1'b1;
                        w_h_nxt        = '0;
                    end
                end else if (w_is_frm) begin
                    w_frame_err_nxt = (r_h != '0) || (r_v != '0);
                    w_sof_nxt       = 1'b1;
                    w_h_nxt         = '0;
                    w_v_nxt         = '0;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_SYNC;
            r_h         <= '0;
            r_v         <= '0;
            r_sof       <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_arm       <= 1'b0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_h         <= w_h_nxt;
            r_v         <= w_v_nxt;
            r_sof       <= w_sof_nxt;
            r_rd_pend   <= fifo_rd_en;
            r_arm       <= 1'b1;
            r_line_err  <= w_line_err_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    axis_skid_buffer #(
        .W (WORD_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_push   (w_push),
        .i_data   (w_push_data),
        .o_occ    (w_occ),
        .o_tvalid (m_axis_video_tvalid),
        .i_tready (m_axis_video_tready),
        .o_tdata  (w_buf_data)
    );

    assign m_axis_video_tdata = w_buf_data[PIX_MSB:0];
    assign m_axis_video_tuser = w_buf_data[BUF_USER_BIT];
    assign m_axis_video_tlast = w_buf_data[BUF_LAST_BIT];
    assign line_err           = r_line_err;
    assign frame_err          = r_frame_err;

endmodule

// File: tb/tb_yuv_fifo_to_axis.sv
// Directed bench for yuv_fifo_to_axis: standard-mode FIFO model, beat capture
// on the falling edge and hand-derived expected beat lists per scenario.
module tb_yuv_fifo_to_axis;

    localparam int H = 640;
    localparam int V = 4;
    localparam int FDEPTH = 16384;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fifo_empty;
    logic [17:0] fifo_dout;
    logic        fifo_rd_en;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;
    logic        line_err;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    yuv_fifo_to_axis #(
        .H_ACTIVE (H),
        .V_ACTIVE (V)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .fifo_empty          (fifo_empty),
        .fifo_dout           (fifo_dout),
        .fifo_rd_en          (fifo_rd_en),
        .m_axis_video_tdata  (tdata),
        .m_axis_video_tvalid (tvalid),
        .m_axis_video_tready (tready),
        .m_axis_video_tuser  (tuser),
        .m_axis_video_tlast  (tlast),
        .line_err            (line_err),
        .frame_err           (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Standard-mode FIFO: dout updates on the clock after rd_en.
    logic [17:0] fmem [FDEPTH];
    int wr_idx = 0;
    int rd_idx = 0;
    int overreads = 0;

    assign fifo_empty = (wr_idx == rd_idx);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (wr_idx == rd_idx) begin
                overreads <= overreads + 1;
            end else begin
                fifo_dout <= fmem[rd_idx % FDEPTH];
                rd_idx    <= rd_idx + 1;
            end
        end
    end

    task automatic push(input logic [17:0] w);
        fmem[wr_idx % FDEPTH] = w;
        wr_idx = wr_idx + 1;
    endtask

    function automatic logic [17:0] pix(input int v);
        logic [15:0] p;
        p = 16'(v);
        return {2'b01, p};
    endfunction

    localparam logic [17:0] FRM  = 18'h20000;
    localparam logic [17:0] LINE = 18'h00000;

    // tready pattern: 0 = always ready, 1 = 1-0-0-1 in 4-cycle phases, 2 = stalled
    int tr_mode = 0;
    int tr_cyc  = 0;

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tr_cyc = tr_cyc + 1;
            case (tr_mode)
                1:       tready = (((tr_cyc / 4) % 4) == 0) || (((tr_cyc / 4) % 4) == 3);
                2:       tready = 1'b0;
                default: tready = 1'b1;
            endcase
        end
    end

    // Beat capture and stall-stability monitoring on the falling edge.
    logic [15:0] rx_data [$];
    logic        rx_user [$];
    logic        rx_last [$];
    int          lerr_cnt = 0;
    int          ferr_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", {13'd0, tvalid, tuser, tlast, tdata}, {13'd0, 1'b1, prev_out});
            end
            if (tvalid && tready) begin
                rx_data.push_back(tdata);
                rx_user.push_back(tuser);
                rx_last.push_back(tlast);
            end
            if (line_err)  lerr_cnt <= lerr_cnt + 1;
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            prev_stall <= tvalid && !tready;
            prev_out   <= {tuser, tlast, tdata};
        end
    end

    logic [15:0] ex_data [$];
    logic        ex_user [$];
    logic        ex_last [$];

    task automatic exp_beat(input int d, input logic u, input logic l);
        ex_data.push_back(16'(d));
        ex_user.push_back(u);
        ex_last.push_back(l);
    endtask

    task automatic check_beats(input string tag);
        int n;
        chk({tag, "_count"}, rx_data.size(), ex_data.size());
        n = (rx_data.size() < ex_data.size()) ? rx_data.size() : ex_data.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), {16'd0, rx_data[i]}, {16'd0, ex_data[i]});
            chk($sformatf("%s_user%0d", tag, i), {31'd0, rx_user[i]}, {31'd0, ex_user[i]});
            chk($sformatf("%s_last%0d", tag, i), {31'd0, rx_last[i]}, {31'd0, ex_last[i]});
        end
        rx_data.delete(); rx_user.delete(); rx_last.delete();
        ex_data.delete(); ex_user.delete(); ex_last.delete();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (fifo_empty && !tvalid && !fifo_rd_en) quiet++;
            else quiet = 0;
        end
        chk({tag, "_idle_reached"}, (quiet >= 4) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;

        // Pixels before any frame marker sit in the FIFO across reset.
        for (int i = 0; i < 10; i++) push(pix(16'hAAAA));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_en",     {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_tvalid",    {31'd0, tvalid},     32'd0);
        chk("rst_tdata",     {16'd0, tdata},      32'd0);
        chk("rst_tuser",     {31'd0, tuser},      32'd0);
        chk("rst_tlast",     {31'd0, tlast},      32'd0);
        chk("rst_line_err",  {31'd0, line_err},   32'd0);
        chk("rst_frame_err", {31'd0, frame_err},  32'd0);
        reset_n = 1'b1;

        wait_idle(200, "presync");
        check_beats("presync");
        chk("presync_lerr", lerr_cnt, 32'd0);
        chk("presync_ferr", ferr_cnt, 32'd0);

        // Full frame at full rate, with first-pixel latency probe.
        @(posedge clk); #1;
        push(FRM);
        wait_idle(200, "t1_frm");
        @(posedge clk); #1;
        push(pix(0));
        #1;
        chk("lat_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        @(posedge clk); #1;
        chk("lat_tvalid_t1", {31'd0, tvalid}, 32'd0);
        @(posedge clk); #1;
        chk("lat_tvalid_t2", {31'd0, tvalid}, 32'd1);
        chk("lat_tdata",     {16'd0, tdata},  32'd0);
        chk("lat_tuser",     {31'd0, tuser},  32'd1);
        for (int i = 1; i < H * V; i++) push(pix(i));
        push(pix(16'h1234));
        for (int i = 0; i < H * V; i++) exp_beat(i, i == 0, (i % H) == H - 1);
        wait_idle(20000, "t1");
        check_beats("t1");
        chk("t1_lerr", lerr_cnt, 32'd0);
        chk("t1_ferr", ferr_cnt, 32'd0);

        // Same frame under a toggling sink.
        tr_mode = 1;
        push(FRM);
        for (int i = 0; i < H * V; i++) push(pix(i));
        push(pix(16'h1234));
        for (int i = 0; i < H * V; i++) exp_beat(i, i == 0, (i % H) == H - 1);
        wait_idle(40000, "t2");
        tr_mode = 0;
        check_beats("t2");
        chk("t2_lerr", lerr_cnt, 32'd0);
        chk("t2_ferr", ferr_cnt, 32'd0);

        // Truncated line 0, then a full line; the trailing line marker at h=0 is ignored.
        push(FRM);
        for (int i = 0; i < 100; i++) push(pix(i));
        push(LINE);
        for (int i = 0; i < H; i++) push(pix(1000 + i));
        push(LINE);
        for (int i = 0; i < 100; i++) exp_beat(i, i == 0, 1'b0);
        for (int i = 0; i < H; i++) exp_beat(1000 + i, 1'b0, i == H - 1);
        wait_idle(5000, "t4");
        check_beats("t4");
        chk("t4_lerr", lerr_cnt, 32'd1);
        chk("t4_ferr", ferr_cnt, 32'd0);

        // Line 1 completes (v_cnt becomes 2), frame marker truncates, then a plain re-arm.
        for (int i = 0; i < H; i++) push(pix(2000 + i));
        push(FRM);
        push(FRM);
        push(pix(3000));
        for (int i = 0; i < H; i++) exp_beat(2000 + i, 1'b0, i == H - 1);
        exp_beat(3000, 1'b1, 1'b0);
        wait_idle(5000, "t5");
        check_beats("t5");
        chk("t5_lerr", lerr_cnt, 32'd1);
        chk("t5_ferr", ferr_cnt, 32'd1);

        // Reset mid-line while stalled with tvalid high.
        tr_mode = 2;
        for (int i = 1; i <= 10; i++) push(pix(3000 + i));
        repeat (10) @(posedge clk);
        #1;
        chk("t6_pre_tvalid", {31'd0, tvalid}, 32'd1);
        chk("t6_pre_tdata",  {16'd0, tdata},  32'd3001);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", {31'd0, tvalid},     32'd0);
        chk("t6_rst_rd_en",  {31'd0, fifo_rd_en}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tr_mode = 0;
        for (int i = 0; i < 5; i++) push(pix(16'hBBBB));
        push(FRM);
        push(pix(4000));
        push(pix(4001));
        exp_beat(4000, 1'b1, 1'b0);
        exp_beat(4001, 1'b0, 1'b0);
        wait_idle(2000, "t6");
        check_beats("t6");
        chk("t6_lerr", lerr_cnt, 32'd1);
        chk("t6_ferr", ferr_cnt, 32'd1);

        chk("no_overread", overreads, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
